// File: rtl/k2red_mul_front.sv
// k2red_mul_front -- operand front end of the K2-RED shift-based reduction
// stage. Multiplies A*B in a three-stage valid/ready pipeline and presents the
// full-width product together with the per-modulus sideband that travelled
// with the operand beat.
//
// Ports:
//   clk, rst                       clock (rising edge), async active-low reset
//   in_valid / in_ready            operand beat handshake
//   A, B                           LOGQ-bit operands
//   qH_in, L1_in, L2_in, L3_in     sideband carried with the beat
//   out_valid / out_ready          product beat handshake
//   C                              2*LOGQ-bit product (registered)
//   qH_out, L1_out, L2_out, L3_out sideband aligned to C (registered)
//
// Optional: define K2RED_MUL_FRONT_STATS_EN to add saturating 32-bit counters
//   beat_cnt  (output transfers) and stall_cnt (cycles out_valid & !out_ready).

`default_nettype none

module k2red_mul_front #(
    parameter int unsigned LOGQ  = 32,
    parameter int unsigned LOGQH = 15,
    parameter int unsigned LOGL  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LOGQ-1:0]     A,
    input  logic [LOGQ-1:0]     B,
    input  logic [LOGQH-1:0]    qH_in,
    input  logic [LOGL-1:0]     L1_in,
    input  logic [LOGL-1:0]     L2_in,
    input  logic [LOGL-1:0]     L3_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*LOGQ-1:0]   C,
    output logic [LOGQH-1:0]    qH_out,
    output logic [LOGL-1:0]     L1_out,
    output logic [LOGL-1:0]     L2_out,
    output logic [LOGL-1:0]     L3_out
`ifdef K2RED_MUL_FRONT_STATS_EN
    ,
    output logic [31:0]         beat_cnt,
    output logic [31:0]         stall_cnt
`endif
);

    localparam int unsigned H = LOGQ / 2;
    localparam int unsigned W = 2 * LOGQ;

    // Stage 1: operand register
    logic             s1_valid;
    logic [LOGQ-1:0]  s1_a;
    logic [LOGQ-1:0]  s1_b;
    logic [LOGQH-1:0] s1_qh;
    logic [LOGL-1:0]  s1_l1;
    logic [LOGL-1:0]  s1_l2;
    logic [LOGL-1:0]  s1_l3;

    // Stage 2: partial products
    logic             s2_valid;
    logic [2*H-1:0]   pp_ll;
    logic [2*H-1:0]   pp_lh;
    logic [2*H-1:0]   pp_hl;
    logic [2*H-1:0]   pp_hh;
    logic [LOGQH-1:0] s2_qh;
    logic [LOGL-1:0]  s2_l1;
    logic [LOGL-1:0]  s2_l2;
    logic [LOGL-1:0]  s2_l3;

    // Stage advance: a stage loads when empty or when its beat moves on.
    // Chained from the output so bubbles collapse in a single cycle.
    logic load1;
    logic load2;
    logic load3;

    always_comb begin
        load3    = !out_valid || out_ready;
        load2    = !s2_valid  || load3;
        load1    = !s1_valid  || load2;
        in_ready = load1;
    end

    // Zero-extended halves so each partial product is computed at 2h bits.
    logic [2*H-1:0] a_lo;
    logic [2*H-1:0] a_hi;
    logic [2*H-1:0] b_lo;
    logic [2*H-1:0] b_hi;

    always_comb begin
        a_lo = {{H{1'b0}}, s1_a[H-1:0]};
        a_hi = {{H{1'b0}}, s1_a[LOGQ-1:H]};
        b_lo = {{H{1'b0}}, s1_b[H-1:0]};
        b_hi = {{H{1'b0}}, s1_b[LOGQ-1:H]};
    end

    // Recombination: the cross-term sum needs 2h+1 bits to keep its carry.
    logic [2*H:0]  mid;
    logic [W-1:0]  mid_ext;
    logic [W-1:0]  c_next;

    always_comb begin
        mid     = {1'b0, pp_lh} + {1'b0, pp_hl};
        mid_ext = W'(mid);
        c_next  = {pp_hh, pp_ll} + (mid_ext << H);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_qh     <= '0;
            s1_l1     <= '0;
            s1_l2     <= '0;
            s1_l3     <= '0;
            s2_valid  <= 1'b0;
            pp_ll     <= '0;
            pp_lh     <= '0;
            pp_hl     <= '0;
            pp_hh     <= '0;
            s2_qh     <= '0;
            s2_l1     <= '0;
            s2_l2     <= '0;
            s2_l3     <= '0;
            out_valid <= 1'b0;
            C         <= '0;
            qH_out    <= '0;
            L1_out    <= '0;
            L2_out    <= '0;
            L3_out    <= '0;
        end else begin
            if (load1) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_a  <= A;
                    s1_b  <= B;
                    s1_qh <= qH_in;
                    s1_l1 <= L1_in;
                    s1_l2 <= L2_in;
                    s1_l3 <= L3_in;
                end
            end
            if (load2) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    pp_ll <= a_lo * b_lo;
                    pp_lh <= a_lo * b_hi;
                    pp_hl <= a_hi * b_lo;
                    pp_hh <= a_hi * b_hi;
                    s2_qh <= s1_qh;
                    s2_l1 <= s1_l1;
                    s2_l2 <= s1_l2;
                    s2_l3 <= s1_l3;
                end
            end
            if (load3) begin
                out_valid <= s2_valid;
                if (s2_valid) begin
                    C      <= c_next;
                    qH_out <= s2_qh;
                    L1_out <= s2_l1;
                    L2_out <= s2_l2;
                    L3_out <= s2_l3;
                end
            end
        end
    end

`ifdef K2RED_MUL_FRONT_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (out_valid && out_ready && (beat_cnt != '1)) begin
                beat_cnt <= beat_cnt + 32'd1;
            end
            if (out_valid && !out_ready && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_k2red_mul_front.sv
// Directed testbench for k2red_mul_front with a scoreboard queue: expected
// products are pushed when an input transfer happens and compared whenever
// out_valid is high (popped on output transfer).

`timescale 1ns/1ps

module tb_k2red_mul_front;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [14:0] qH_in = '0;
    logic [3:0]  L1_in = '0;
    logic [3:0]  L2_in = '0;
    logic [3:0]  L3_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] C;
    logic [14:0] qH_out;
    logic [3:0]  L1_out;
    logic [3:0]  L2_out;
    logic [3:0]  L3_out;
`ifdef K2RED_MUL_FRONT_STATS_EN
    logic [31:0] beat_cnt;
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    k2red_mul_front #(
        .LOGQ(32),
        .LOGQH(15),
        .LOGL(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .A(A),
        .B(B),
        .qH_in(qH_in),
        .L1_in(L1_in),
        .L2_in(L2_in),
        .L3_in(L3_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .C(C),
        .qH_out(qH_out),
        .L1_out(L1_out),
        .L2_out(L2_out),
        .L3_out(L3_out)
`ifdef K2RED_MUL_FRONT_STATS_EN
        ,
        .beat_cnt(beat_cnt),
        .stall_cnt(stall_cnt)
`endif
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [90:0] q[$];
    logic        acc;
    logic        last_ready;
    logic [90:0] obs;
    int unsigned idx;

    assign obs = {C, qH_out, L1_out, L2_out, L3_out};

    function automatic logic [90:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [14:0] qh, input logic [3:0] l1,
                                          input logic [3:0] l2, input logic [3:0] l3);
        logic [63:0] p;
        p = {32'b0, a} * {32'b0, b};
        return {p, qh, l1, l2, l3};
    endfunction

    task automatic chk(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        n_vec++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [14:0] qh,
                         input logic [3:0] l1, input logic [3:0] l2, input logic [3:0] l3);
        A = a; B = b; qH_in = qh; L1_in = l1; L2_in = l2; L3_in = l3;
    endtask

    // One clock cycle: evaluate mid-cycle, update the scoreboard, cross the edge.
    // exp_ov < 0 skips the out_valid check.
    task automatic tick(input int exp_ov);
        #1;
        last_ready = in_ready;
        acc = in_valid && in_ready;
        if (exp_ov >= 0) chk("out_valid", 128'(out_valid), 128'(exp_ov[0]));
        if (out_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_beat", 128'(out_valid), 128'(0));
            end else begin
                chk("beat", 128'(obs), 128'(q[0]));
                if (out_ready) void'(q.pop_front());
            end
        end
        if (acc) q.push_back(model(A, B, qH_in, L1_in, L2_in, L3_in));
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0;
        q.delete();
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #3;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_outputs", 128'(obs), 128'(0));
        do_reset();

        // Basic, latency 3
        out_ready = 1'b1;
        drive(32'd3, 32'd5, 15'h4008, 4'd2, 4'd1, 4'd3);
        in_valid = 1'b1;
        tick(0);
        chk("basic_accept", 128'(acc), 128'(1));
        in_valid = 1'b0;
        tick(0);
        tick(0);
        tick(1);
        tick(0);
        chk("basic_drained", 128'(q.size()), 128'(0));

        // Max operands and middle-sum carry
        drive(32'hFFFF_FFFF, 32'hFFFF_FFFF, 15'h7FFF, 4'hF, 4'hF, 4'hF);
        in_valid = 1'b1;
        tick(-1);
        drive(32'h8000_0000, 32'd2, 15'h0001, 4'd5, 4'd6, 4'd7);
        tick(-1);
        drive(32'h0001_FFFF, 32'hFFFF_0001, 15'h1234, 4'd9, 4'd0, 4'd4);
        tick(-1);
        in_valid = 1'b0;
        for (int n = 0; n < 10 && q.size() != 0; n++) tick(-1);
        chk("max_drained", 128'(q.size()), 128'(0));

        // Streaming 8 back-to-back beats
        for (int t = 0; t < 12; t++) begin
            if (t < 8) begin
                drive(32'(t + 1), 32'(t + 2), 15'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick((t >= 3 && t <= 10) ? 1 : 0);
            if (t < 8) chk("stream_accept", 128'(acc), 128'(1));
        end
        chk("stream_drained", 128'(q.size()), 128'(0));

        // Back-pressure: capacity 3, held output, simultaneous in/out
        do_reset();
        out_ready = 1'b0;
        idx = 0;
        for (int t = 0; t < 8; t++) begin
            drive(idx + 1, idx + 2, 15'(idx + 16'h100), 4'(idx), 4'(idx + 1), 4'(idx + 2));
            in_valid = 1'b1;
            tick(-1);
            if (acc) idx++;
        end
        chk("bp_accepted", 128'(idx), 128'(3));
        chk("bp_in_ready_low", 128'(in_ready), 128'(0));
        chk("bp_held_c", 128'(C), 128'(2));
        out_ready = 1'b1;
        tick(1);
        chk("bp_simul_ready", 128'(last_ready), 128'(1));
        if (acc) idx++;
        in_valid = 1'b0;
        for (int n = 0; n < 20 && q.size() != 0; n++) tick(-1);
        chk("bp_accepted_all", 128'(idx), 128'(4));
        chk("bp_drained", 128'(q.size()), 128'(0));
        tick(0);
        tick(0);
`ifdef K2RED_MUL_FRONT_STATS_EN
        chk("stall_cnt", 128'(stall_cnt), 128'(5));
        chk("beat_cnt", 128'(beat_cnt), 128'(4));
`endif

        // Reset mid-flight
        out_ready = 1'b0;
        drive(32'd11, 32'd13, 15'h0AAA, 4'd1, 4'd2, 4'd3);
        in_valid = 1'b1;
        tick(0);
        drive(32'd5, 32'd6, 15'h0555, 4'd4, 4'd5, 4'd6);
        tick(0);
        in_valid = 1'b0;
        tick(0);
        tick(1);
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", 128'(out_valid), 128'(0));
        chk("midrst_outputs", 128'(obs), 128'(0));
        q.delete();
        @(posedge clk);
        #2;
        rst = 1'b1;
        out_ready = 1'b1;
        for (int n = 0; n < 5; n++) tick(0);
        drive(32'd7, 32'd9, 15'h0042, 4'd8, 4'd9, 4'd10);
        in_valid = 1'b1;
        tick(0);
        in_valid = 1'b0;
        tick(0);
        tick(0);
        tick(1);
        chk("after_rst_c", 128'(C), 128'(63));
        tick(0);
        chk("final_drained", 128'(q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
